// File: rtl/riscv_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pipe_pkg
//  Brief    : Shared widths, ALU encodings and the ID/EX bundle for the RV64 pipe.
//  Revision : 1.0
// ============================================================================
package riscv_pipe_pkg;

   localparam int XLEN  = 64;
   localparam int REGW  = 5;
   localparam int CTRLW = 4;

   typedef enum logic [CTRLW-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6
   } alu_op_e;

   // Source addresses travel with the data so EX-time forwarding can match them.
   typedef struct packed {
      logic [REGW-1:0]  rs1_addr;
      logic [REGW-1:0]  rs2_addr;
      logic [REGW-1:0]  rd;
      logic [CTRLW-1:0] alu_ctrl;
      logic             is_load;
      logic             reg_write;
      logic [XLEN-1:0]  rs1_data;
      logic [XLEN-1:0]  rs2_data;
   } id_ex_t;

   function automatic logic fwd_hit(input logic            reg_write,
                                    input logic [REGW-1:0] rd,
                                    input logic [REGW-1:0] src);
      return reg_write && (rd != '0) && (rd == src);
   endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_operand_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_mux
//  Brief    : Operand select: MEM producer, then WB producer, else registered value.
//  Revision : 1.0
// ============================================================================
module fwd_mux
   import riscv_pipe_pkg::*;
(
   input  logic [REGW-1:0] src,
   input  logic [XLEN-1:0] regval,
   input  logic [REGW-1:0] exm_rd,
   input  logic            exm_reg_write,
   input  logic [XLEN-1:0] exm_result,
   input  logic [REGW-1:0] mwb_rd,
   input  logic            mwb_reg_write,
   input  logic [XLEN-1:0] mwb_result,
   output logic [XLEN-1:0] operand
);

   always_comb begin
      operand = regval;
      if (fwd_hit(exm_reg_write, exm_rd, src)) begin
         operand = exm_result;
      end else if (fwd_hit(mwb_reg_write, mwb_rd, src)) begin
         operand = mwb_result;
      end
   end

endmodule
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_operand_stage
//  Brief    : ID/EX pipeline register with load-use bubble and EX-time forwarding.
//  Revision : 1.0
// ============================================================================
module id_ex_operand_stage
   import riscv_pipe_pkg::*;
#(
   parameter int CNTW = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   output logic             id_ready,
   input  logic [REGW-1:0]  id_rs1_addr,
   input  logic [REGW-1:0]  id_rs2_addr,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [REGW-1:0]  id_rd_addr,
   input  logic [CTRLW-1:0] id_alu_ctrl,
   input  logic             id_is_load,
   input  logic             id_reg_write,
   input  logic [REGW-1:0]  exm_rd,
   input  logic             exm_reg_write,
   input  logic [XLEN-1:0]  exm_result,
   input  logic [REGW-1:0]  mwb_rd,
   input  logic             mwb_reg_write,
   input  logic [XLEN-1:0]  mwb_result,
   input  logic             flush,
   input  logic             ex_ready,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_rs1,
   output logic [XLEN-1:0]  ex_rs2,
   output logic [REGW-1:0]  ex_rd,
   output logic [CTRLW-1:0] ex_alu_ctrl,
   output logic             ex_is_load,
   output logic             ex_reg_write,
   output logic [CNTW-1:0]  perf_bubbles
);

   id_ex_t          r_ex;
   logic            r_ex_valid;
   logic [CNTW-1:0] r_perf;

   logic   w_adv;
   logic   w_load_use;
   logic   w_rs1_hit;
   logic   w_rs2_hit;
   id_ex_t w_id;

   assign w_rs1_hit  = id_uses_rs1 && (id_rs1_addr == r_ex.rd);
   assign w_rs2_hit  = id_uses_rs2 && (id_rs2_addr == r_ex.rd);
   assign w_load_use = id_valid && r_ex_valid && r_ex.is_load && r_ex.reg_write &&
                       (r_ex.rd != '0) && (w_rs1_hit || w_rs2_hit);
   assign w_adv      = !r_ex_valid || ex_ready;
   assign id_ready   = w_adv && !w_load_use;

   always_comb begin
      w_id           = '0;
      w_id.rs1_addr  = id_rs1_addr;
      w_id.rs2_addr  = id_rs2_addr;
      w_id.rd        = id_rd_addr;
      w_id.alu_ctrl  = id_alu_ctrl;
      w_id.is_load   = id_is_load;
      w_id.reg_write = id_reg_write;
      w_id.rs1_data  = id_rs1_data;
      w_id.rs2_data  = id_rs2_data;
   end

   // Flush outranks a stalled EX and discards any same-cycle ID handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex_valid <= 1'b0;
         r_ex       <= '0;
         r_perf     <= '0;
      end else if (flush) begin
         r_ex_valid     <= 1'b0;
         r_ex.reg_write <= 1'b0;
         r_ex.is_load   <= 1'b0;
      end else if (w_adv) begin
         if (id_valid && !w_load_use) begin
            r_ex_valid <= 1'b1;
            r_ex       <= w_id;
         end else begin
            r_ex_valid <= 1'b0;
            r_ex       <= '0;
            if (w_load_use) begin
               r_perf <= r_perf + 1'b1;
            end
         end
      end
   end

   fwd_mux u_fwd_rs1 (
      .src           (r_ex.rs1_addr),
      .regval        (r_ex.rs1_data),
      .exm_rd        (exm_rd),
      .exm_reg_write (exm_reg_write),
      .exm_result    (exm_result),
      .mwb_rd        (mwb_rd),
      .mwb_reg_write (mwb_reg_write),
      .mwb_result    (mwb_result),
      .operand       (ex_rs1)
   );

   fwd_mux u_fwd_rs2 (
      .src           (r_ex.rs2_addr),
      .regval        (r_ex.rs2_data),
      .exm_rd        (exm_rd),
      .exm_reg_write (exm_reg_write),
      .exm_result    (exm_result),
      .mwb_rd        (mwb_rd),
      .mwb_reg_write (mwb_reg_write),
      .mwb_result    (mwb_result),
      .operand       (ex_rs2)
   );

   assign ex_valid     = r_ex_valid;
   assign ex_rd        = r_ex.rd;
   assign ex_alu_ctrl  = r_ex.alu_ctrl;
   assign ex_is_load   = r_ex.is_load;
   assign ex_reg_write = r_ex.reg_write;
   assign perf_bubbles = r_perf;

endmodule
`default_nettype wire
